// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment scan driver
// Purpose: digit-code type, blank pattern and the 16-entry active-low segment table.
// Ports: none (package).
package seg7_pkg;

  typedef logic [3:0] digit_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Highest code that renders in decimal-only mode.
  localparam digit_t DEC_MAX = 4'd9;

  // Entry [n] is the pattern for code n; listed from F down to 0.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08,  // F E d C b A
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,         // 9 8 7 6 5
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40          // 4 3 2 1 0
  };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational digit-code to segment lookup
// Purpose: maps a 4-bit code to an active-low segment pattern.
// Ports: code_i - digit code; seg_o - {g,f,e,d,c,b,a}, active-low.
// HEX_MODE=0 renders codes 10..15 as blank, HEX_MODE=1 as A,b,C,d,E,F.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit HEX_MODE = 1'b0
) (
  input  digit_t     code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_CODES[code_i];
    if (!HEX_MODE && (code_i > DEC_MAX)) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit seven-segment scan driver
// Purpose: double-buffered digit frame scanned one anode at a time with
//   per-digit enable, decimal points, leading-zero blanking and optional hex.
// Ports: clk/rst - clock and synchronous active-high reset;
//   load, digits_in, dp_in, digit_en, lz_blank - pending-frame capture;
//   seg, dp, an - active-low display pins; upd_done - frame-swap pulse.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter bit HEX_MODE    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    upd_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic                    pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;
  logic                    flag_q, flag_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    upd_q, upd_d;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_run;
  logic                    zero_like;
  digit_t                  sel_code;
  logic [6:0]              dec_seg;
  logic                    blank;

  // Scan timing and frame buffering. The pending->active swap only happens
  // on the last cycle of the last digit, so a frame is never shown torn.
  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    idx_d      = idx_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_en_d  = pend_en_q;
    pend_lz_d  = pend_lz_q;
    flag_d     = flag_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    act_lz_d   = act_lz_q;
    upd_d      = 1'b0;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      if ((idx_q == IDX_LAST) && flag_q) begin
        act_dig_d = pend_dig_q;
        act_dp_d  = pend_dp_q;
        act_en_d  = pend_en_q;
        act_lz_d  = pend_lz_q;
        flag_d    = 1'b0;
        upd_d     = 1'b1;
      end
    end

    // Applied after the swap: a load on the boundary lands in pending and
    // keeps the flag set for the next frame.
    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_en_d  = digit_en;
      pend_lz_d  = lz_blank;
      flag_d     = 1'b1;
    end
  end

  // Leading-zero run from the top digit down; digit 0 is always exempt.
  always_comb begin
    lz_mask   = '0;
    lz_run    = act_lz_d;
    zero_like = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_like  = !act_en_d[i] || ((act_dig_d[4*i +: 4] == 4'd0) && !act_dp_d[i]);
      lz_run     = lz_run && zero_like;
      lz_mask[i] = lz_run;
    end
  end

  // Outputs are computed from next-state values so the registered pins line
  // up with the scan index: the new digit 0 shows in the upd_done cycle.
  assign sel_code = act_dig_d[{idx_d, 2'b00} +: 4];

  seg7_decode #(
    .HEX_MODE(HEX_MODE)
  ) u_decode (
    .code_i(sel_code),
    .seg_o (dec_seg)
  );

  always_comb begin
    blank        = !act_en_d[idx_d] || lz_mask[idx_d] || (dec_seg == SEG_BLANK);
    an_d         = '1;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b1;
    if (!blank) begin
      an_d[idx_d] = 1'b0;
      seg_d       = dec_seg;
      dp_d        = ~act_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '0;
      pend_lz_q  <= 1'b0;
      flag_q     <= 1'b0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      act_lz_q   <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      an_q       <= '1;
      upd_q      <= 1'b0;
    end else begin
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_en_q  <= pend_en_d;
      pend_lz_q  <= pend_lz_d;
      flag_q     <= flag_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
      act_lz_q   <= act_lz_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      upd_q      <= upd_d;
    end
  end

  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;
  assign upd_done = upd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
// Purpose: two 4-digit instances (decimal and hex mode) driven by shared inputs.
// Ports: none (top-level bench).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_blank = 1'b0;

  logic [6:0]  seg, seg_h;
  logic        dp, dp_h;
  logic [3:0]  an, an_h;
  logic        upd_done, upd_h;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] e_an[4];
  logic [6:0] e_seg[4];
  logic       e_dp[4];
  logic [3:0] h_an[4];
  logic [6:0] h_seg[4];
  logic       h_dp[4];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank),
    .seg(seg), .dp(dp), .an(an), .upd_done(upd_done)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1'b1)) dut_h (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank),
    .seg(seg_h), .dp(dp_h), .an(an_h), .upd_done(upd_h)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                         input logic [3:0] e, input logic lz);
    digits_in = d;
    dp_in     = p;
    digit_en  = e;
    lz_blank  = lz;
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  task automatic exp_slot(input int s, input logic [3:0] a, input logic [6:0] sg, input logic d);
    e_an[s] = a;  e_seg[s] = sg;  e_dp[s] = d;
    h_an[s] = a;  h_seg[s] = sg;  h_dp[s] = d;
  endtask

  task automatic exp_hex(input int s, input logic [3:0] a, input logic [6:0] sg, input logic d);
    h_an[s] = a;  h_seg[s] = sg;  h_dp[s] = d;
  endtask

  task automatic wait_upd();
    int n = 0;
    while (upd_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (upd_done !== 1'b1) check_eq("upd timeout", upd_done, 1);
  endtask

  // Called on the first cycle of a fresh frame (upd_done high).
  task automatic check_frame(input int nframes);
    for (int k = 0; k < 16 * nframes; k++) begin
      int s;
      if (k > 0) step();
      s = (k / 4) % 4;
      check_eq($sformatf("an s%0d k%0d", s, k), an, e_an[s]);
      check_eq($sformatf("seg s%0d k%0d", s, k), seg, e_seg[s]);
      check_eq($sformatf("dp s%0d k%0d", s, k), dp, e_dp[s]);
      check_eq($sformatf("upd k%0d", k), upd_done, (k == 0));
      check_eq($sformatf("hex an s%0d", s), an_h, h_an[s]);
      check_eq($sformatf("hex seg s%0d", s), seg_h, h_seg[s]);
      check_eq($sformatf("hex dp s%0d", s), dp_h, h_dp[s]);
      check_eq($sformatf("hex upd k%0d", k), upd_h, (k == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    repeat (3) step();
    check_eq("rst an", an, 4'b1111);
    check_eq("rst seg", seg, 7'h7F);
    check_eq("rst dp", dp, 1'b1);
    check_eq("rst upd", upd_done, 1'b0);
    rst = 1'b0;
    repeat (20) begin
      step();
      check_eq("dark an", an, 4'b1111);
      check_eq("dark upd", upd_done, 1'b0);
    end

    // Plain decimal frame 1234.
    exp_slot(0, 4'b1110, 7'h19, 1'b1);
    exp_slot(1, 4'b1101, 7'h30, 1'b1);
    exp_slot(2, 4'b1011, 7'h24, 1'b1);
    exp_slot(3, 4'b0111, 7'h79, 1'b1);
    do_load(16'h1234, 4'b0000, 4'b1111, 1'b0);
    wait_upd();
    check_frame(2);

    // Leading-zero blanking of 0050.
    exp_slot(0, 4'b1110, 7'h40, 1'b1);
    exp_slot(1, 4'b1101, 7'h12, 1'b1);
    exp_slot(2, 4'b1111, 7'h7F, 1'b1);
    exp_slot(3, 4'b1111, 7'h7F, 1'b1);
    do_load(16'h0050, 4'b0000, 4'b1111, 1'b1);
    wait_upd();
    check_frame(1);

    // A decimal point on slot 2 ends the zero run there.
    exp_slot(2, 4'b1011, 7'h40, 1'b0);
    do_load(16'h0050, 4'b0100, 4'b1111, 1'b1);
    wait_upd();
    check_frame(1);

    // Disabled slots stay dark even with dp requested.
    exp_slot(0, 4'b1110, 7'h02, 1'b0);
    exp_slot(1, 4'b1111, 7'h7F, 1'b1);
    exp_slot(2, 4'b1011, 7'h00, 1'b0);
    exp_slot(3, 4'b1111, 7'h7F, 1'b1);
    do_load(16'h9876, 4'b1111, 4'b0101, 1'b0);
    wait_upd();
    check_frame(1);

    // Hex codes: blank in decimal mode, letters in hex mode.
    for (int s = 0; s < 4; s++) exp_slot(s, 4'b1111, 7'h7F, 1'b1);
    exp_hex(0, 4'b1110, 7'h08, 1'b1);
    exp_hex(1, 4'b1101, 7'h46, 1'b1);
    exp_hex(2, 4'b1011, 7'h21, 1'b1);
    exp_hex(3, 4'b0111, 7'h06, 1'b1);
    do_load(16'hEDCA, 4'b0000, 4'b1111, 1'b0);
    wait_upd();
    check_frame(1);

    // Last-wins loads, then a load on the boundary cycle itself.
    step();
    repeat (2) begin
      step();
      check_eq("no early upd", upd_done, 1'b0);
    end
    do_load(16'h1111, 4'b0000, 4'b1111, 1'b0);
    repeat (2) step();
    do_load(16'h2222, 4'b0000, 4'b1111, 1'b0);
    repeat (9) begin
      step();
      check_eq("no mid-frame upd", upd_done, 1'b0);
    end
    exp_slot(0, 4'b1110, 7'h24, 1'b1);
    exp_slot(1, 4'b1101, 7'h24, 1'b1);
    exp_slot(2, 4'b1011, 7'h24, 1'b1);
    exp_slot(3, 4'b0111, 7'h24, 1'b1);
    digits_in = 16'h3333;
    load      = 1'b1;
    step();
    load      = 1'b0;
    check_frame(1);
    for (int s = 0; s < 4; s++) begin
      e_seg[s] = 7'h30;
      h_seg[s] = 7'h30;
    end
    wait_upd();
    check_frame(1);

    // Reset mid-scan with a pending frame.
    do_load(16'h4444, 4'b0000, 4'b1111, 1'b0);
    repeat (5) step();
    rst = 1'b1;
    step();
    check_eq("mid rst an", an, 4'b1111);
    check_eq("mid rst seg", seg, 7'h7F);
    check_eq("mid rst dp", dp, 1'b1);
    check_eq("mid rst upd", upd_done, 1'b0);
    check_eq("mid rst hex an", an_h, 4'b1111);
    rst = 1'b0;
    repeat (40) begin
      step();
      check_eq("post rst upd", upd_done, 1'b0);
      check_eq("post rst an", an, 4'b1111);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed N-digit seven-segment display driver: the parametrised successor to the single-digit BCD-to-segment converter. It holds a double-buffered frame of 4-bit digit codes and scans them onto the shared segment bus, one anode at a time, at a programmable refresh rate. It adds per-digit enable, decimal points, leading-zero blanking and an optional hex mode. It sits between the arithmetic datapath (multiplier/BCD converter outputs) and the board's anode/segment pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned; range 2..16.
- REFRESH_DIV, 100000, clock cycles each digit stays lit; minimum 2.
- HEX_MODE, 0, 0: codes 10..15 blank; 1: codes 10..15 render A,b,C,d,E,F.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures the inputs below into the pending buffer.
- digits_in  in  4*NUM_DIGITS  digit codes; digit i = digits_in[4i+3:4i], digit 0 least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  per-digit enable, 0 = slot always blank.
- lz_blank  in  1  leading-zero blanking enable, captured with load.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anodes, active-low, one-hot-low or all-high.
- upd_done  out  1  one-cycle pulse: pending frame became active.

## Operation
- Segment encoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; HEX_MODE=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; otherwise 1111111.
- Registers: pending frame + pending flag; active frame (digits, dp, enables, lz_blank); divider counter; scan index.
- load: pending <= inputs, flag <= 1. Repeated loads before transfer: last wins, one upd_done.
- Frame boundary: counter == REFRESH_DIV-1 and index == NUM_DIGITS-1. If flag set: active <= pending, flag <= 0, upd_done <= 1. Display never tears mid-frame.
- load coincident with boundary: transfer uses pending contents before the load; new data lands in pending, flag stays 1.
- Leading-zero blanking (active lz_blank = 1): scanning from digit NUM_DIGITS-1 downward, a slot is blanked while its code is 0 with dp bit 0, or it is disabled; first slot failing this ends the run. Digit 0 is never LZ-blanked.
- Blank slot (disabled, LZ-blanked, or code blanks): an all ones, seg = 1111111, dp = 1.
- Lit slot: an bit[index] = 0, others 1; seg from table; dp = ~dp bit.

## Timing
- Reset values: counter 0, index 0, active and pending frames 0 (all digits disabled), flag 0; an = all ones, seg = 1111111, dp = 1, upd_done = 0. Display stays dark until first transfer.
- Counter 0..REFRESH_DIV-1, wraps; on wrap, index advances, NUM_DIGITS-1 wraps to 0.
- an/seg/dp registered: reflect index and active frame with one cycle latency; each slot is lit exactly REFRESH_DIV cycles.
- upd_done high the cycle after the boundary edge; new digit 0 appears on outputs that same cycle.
- rst mid-frame: all state returns to reset values at the next edge; pending data discarded, no upd_done.

## Structure
- seg7_pkg: SEG_BLANK = 7'h7F, the 16-entry encoding constants, digit-code typedef (4-bit).
- Sub-module seg7_decode: combinational code-to-segment lookup, HEX_MODE parameter; instantiated once on the muxed digit.

## Test plan
- NUM_DIGITS=4, REFRESH_DIV=4 throughout. Reset 3 cycles -> an=1111, seg=1111111, dp=1, upd_done=0; holds until a load transfers.
- load digits_in=16'h1234, digit_en=1111, dp_in=0000 -> one upd_done at boundary; then an=1110/seg=0011001, 1101/0110000, 1011/0100100, 0111/1111001, 4 cycles each, repeating.
- load 16'h0050, lz_blank=1, en=1111 -> slots 3,2 an=1111; slot 1 seg=0010010; slot 0 seg=1000000. Same with dp_in=0100 -> slot 2 lit with 1000000, dp=0.
- HEX_MODE=0, digit 0 = 4'hA -> slot 0 blank (an=1111, seg=1111111); HEX_MODE=1 -> an=1110, seg=0001000.
- Loads 16'h1111 then 16'h2222 mid-frame, plus load 16'h3333 on the boundary cycle -> one upd_done showing 2222; 3333 transfers on the following boundary with a second upd_done.
- Assert rst mid-scan with flag set -> next cycle reset values; no upd_done at the following boundary.
